// File: rtl/tiny_seq_pkg.sv
// Shared constants for the tiny slot sequencer: register map, CTRL bits, FSM encoding.
package tiny_seq_pkg;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned ST_W  = 3;

  localparam logic [2:0] ADR_CTRL   = 3'd0;
  localparam logic [2:0] ADR_SEL    = 3'd1;
  localparam logic [2:0] ADR_DIV    = 3'd2;
  localparam logic [2:0] ADR_IN     = 3'd3;
  localparam logic [2:0] ADR_OUT    = 3'd4;
  localparam logic [2:0] ADR_STATUS = 3'd5;

  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_SCAN   = 1;
  localparam int unsigned CTRL_SRC    = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP   = 3'd1;
  localparam logic [ST_W-1:0] ST_CLK_HI  = 3'd2;
  localparam logic [ST_W-1:0] ST_CLK_LO  = 3'd3;
  localparam logic [ST_W-1:0] ST_CAPTURE = 3'd4;

  localparam logic [DIV_W-1:0] DIV_RESET = 16'd1;

endpackage

// File: rtl/tiny_seq_regs.sv
// Wishbone register file: decode, single-cycle ack, CTRL/SEL/DIV/IN storage, done W1C and irq.
module tiny_seq_regs
  import tiny_seq_pkg::*;
#(
  parameter int unsigned N_MODULES = 4,
  parameter int unsigned SEL_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stb,
  input  logic             cyc,
  input  logic             we,
  input  logic [2:0]       adr,
  input  logic [31:0]      dat_i,
  output logic             ack,
  output logic [31:0]      dat_o,
  input  logic             busy,
  input  logic [15:0]      out_word,
  input  logic             done_set,
  output logic [3:0]       ctrl,
  output logic [SEL_W-1:0] sel,
  output logic [DIV_W-1:0] div,
  output logic [6:0]       in_bits,
  output logic             done,
  output logic             irq
);

  logic             ack_d;
  logic [31:0]      dat_d;
  logic [3:0]       ctrl_d;
  logic [SEL_W-1:0] sel_d;
  logic [DIV_W-1:0] div_d;
  logic [6:0]       in_d;
  logic             done_d;
  logic             irq_d;
  logic             access;
  logic [31:0]      rdata;

  always_comb begin
    ctrl_d = ctrl;
    sel_d  = sel;
    div_d  = div;
    in_d   = in_bits;
    done_d = done;
    rdata  = 32'd0;
    access = stb & cyc & ~ack;
    ack_d  = access;

    if (access && we) begin
      case (adr)
        ADR_CTRL:   ctrl_d = dat_i[3:0];
        ADR_SEL:    if (dat_i < 32'(N_MODULES)) sel_d = dat_i[SEL_W-1:0];
        ADR_DIV:    div_d = dat_i[15:0];
        ADR_IN:     in_d = dat_i[7:1];
        ADR_STATUS: if (dat_i[1]) done_d = 1'b0;
        default:    ;
      endcase
    end
    // A completed capture in the same cycle as a clear keeps done set.
    if (done_set) done_d = 1'b1;

    case (adr)
      ADR_CTRL:   rdata = 32'(ctrl);
      ADR_SEL:    rdata = 32'(sel);
      ADR_DIV:    rdata = 32'(div);
      ADR_IN:     rdata = {24'd0, in_bits, 1'b0};
      ADR_OUT:    rdata = 32'(out_word);
      ADR_STATUS: rdata = {30'd0, done, busy};
      default:    rdata = 32'd0;
    endcase
    dat_d = access ? rdata : 32'd0;
    irq_d = done_d & ctrl_d[CTRL_IRQ_EN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack     <= 1'b0;
      dat_o   <= 32'd0;
      ctrl    <= 4'd0;
      sel     <= '0;
      div     <= DIV_RESET;
      in_bits <= 7'd0;
      done    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      ack     <= ack_d;
      dat_o   <= dat_d;
      ctrl    <= ctrl_d;
      sel     <= sel_d;
      div     <= div_d;
      in_bits <= in_d;
      done    <= done_d;
      irq     <= irq_d;
    end
  end

endmodule

// File: rtl/tiny_slot_sequencer.sv
// Shares the user area among N_MODULES tiny modules: clocks the active slot, drives its data,
// and captures its output for the pads and Wishbone readback.
module tiny_slot_sequencer
  import tiny_seq_pkg::*;
#(
  parameter int unsigned N_MODULES = 4,
  parameter int unsigned SEL_W     = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic [7:0]             io_in_i,
  output logic [7:0]             io_out_o,
  output logic [N_MODULES*8-1:0] mod_in_o,
  input  logic [N_MODULES*8-1:0] mod_out_i,
  output logic                   busy_o,
  output logic                   irq_o
);

  logic [3:0]             ctrl;
  logic [SEL_W-1:0]       sel;
  logic [DIV_W-1:0]       div;
  logic [6:0]             in_bits;
  logic                   done;
  logic                   done_set;

  logic [ST_W-1:0]        state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       slot_q, slot_d;
  logic [6:0]             data_q, data_d;
  logic [SEL_W-1:0]       out_slot_q, out_slot_d;
  logic [7:0]             out_data_d;
  logic [N_MODULES*8-1:0] mod_in_d;
  logic [DIV_W-1:0]       reload;
  logic [6:0]             src_val;
  logic [7:0]             cap_data;

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0], io_in_i[0]};

  tiny_seq_regs #(
    .N_MODULES(N_MODULES),
    .SEL_W    (SEL_W)
  ) u_regs (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .stb     (wbs_stb_i),
    .cyc     (wbs_cyc_i),
    .we      (wbs_we_i),
    .adr     (wbs_adr_i[4:2]),
    .dat_i   (wbs_dat_i),
    .ack     (wbs_ack_o),
    .dat_o   (wbs_dat_o),
    .busy    (busy_o),
    .out_word({8'(out_slot_q), io_out_o}),
    .done_set(done_set),
    .ctrl    (ctrl),
    .sel     (sel),
    .div     (div),
    .in_bits (in_bits),
    .done    (done),
    .irq     (irq_o)
  );

  // Next-state, slot/data tracking and slot mux.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    data_d     = data_q;
    out_slot_d = out_slot_q;
    out_data_d = io_out_o;
    done_set   = 1'b0;
    mod_in_d   = '0;
    cap_data   = 8'd0;
    reload     = (div == '0) ? '0 : div - DIV_W'(1);
    src_val    = ctrl[CTRL_SRC] ? io_in_i[7:1] : in_bits;

    for (int unsigned k = 0; k < N_MODULES; k++) begin
      if (slot_q == SEL_W'(k)) cap_data = mod_out_i[k*8 +: 8];
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl[CTRL_RUN]) begin
          state_d = ST_SETUP;
          slot_d  = sel;
          cnt_d   = reload;
        end
      end
      ST_SETUP, ST_CLK_HI, ST_CLK_LO: begin
        if (cnt_q == '0) begin
          cnt_d   = reload;
          state_d = (state_q == ST_SETUP)  ? ST_CLK_HI :
                    (state_q == ST_CLK_HI) ? ST_CLK_LO : ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_CAPTURE: begin
        out_data_d = cap_data;
        out_slot_d = slot_q;
        cnt_d      = reload;
        if (!ctrl[CTRL_RUN]) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end else if (!ctrl[CTRL_SCAN]) begin
          state_d  = ST_SETUP;
          slot_d   = sel;
          done_set = 1'b1;
        end else begin
          state_d = ST_SETUP;
          if (slot_q == SEL_W'(N_MODULES - 1)) begin
            slot_d   = '0;
            done_set = 1'b1;
          end else begin
            slot_d = slot_q + SEL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Data follows the source through SETUP, including the exit edge, then stays frozen.
    if (state_q == ST_SETUP || state_d == ST_SETUP) data_d = src_val;

    if (state_d != ST_IDLE) begin
      for (int unsigned k = 0; k < N_MODULES; k++) begin
        if (slot_d == SEL_W'(k)) mod_in_d[k*8 +: 8] = {data_d, state_d == ST_CLK_HI};
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      slot_q     <= '0;
      data_q     <= 7'd0;
      out_slot_q <= '0;
      io_out_o   <= 8'd0;
      mod_in_o   <= '0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      data_q     <= data_d;
      out_slot_q <= out_slot_d;
      io_out_o   <= out_data_d;
      mod_in_o   <= mod_in_d;
      busy_o     <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_tiny_slot_sequencer.sv
// Directed bench for tiny_slot_sequencer with immediate assertions at each check point.
module tb_tiny_slot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic [7:0]  io_in_i, io_out_o;
  logic [31:0] mod_in_o, mod_out_i;
  logic        busy_o, irq_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tiny_slot_sequencer #(.N_MODULES(4), .SEL_W(4)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .io_in_i   (io_in_i),
    .io_out_o  (io_out_o),
    .mod_in_o  (mod_in_o),
    .mod_out_i (mod_out_i),
    .busy_o    (busy_o),
    .irq_o     (irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One access; ack must be high exactly one cycle after the strobe.
  task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] q);
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = w;
    wbs_adr_i = {27'd0, a, 2'b00}; wbs_dat_i = d;
    @(posedge clk); #1;
    check("ack_1cyc", 32'(wbs_ack_o), 32'd1);
    q = wbs_dat_o;
    @(negedge clk);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(a, 1'b1, d, q);
  endtask

  task automatic wb_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_xfer(a, 1'b0, 32'd0, q);
    check(tag, q, exp);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 64 && busy_o; i++) step(1);
    check(tag, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
    io_in_i = 8'd0;
    mod_out_i = 32'h135A_1110;

    // Reset state
    step(2);
    check("rst_mod_in", mod_in_o, 32'd0);
    check("rst_io_out", 32'(io_out_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wb_read("rst_div", 3'd2, 32'd1);
    wb_read("rst_ctrl", 3'd0, 32'd0);
    wb_read("unmapped", 3'd7, 32'd0);

    // SEL out of range is ignored
    wb_write(3'd1, 32'd2);
    wb_write(3'd1, 32'd7);
    wb_read("sel_keep", 3'd1, 32'd2);

    // Single mode, slot 2, DIV=3
    wb_write(3'd2, 32'd3);
    wb_write(3'd3, 32'hA4);
    wb_read("in_rd", 3'd3, 32'hA4);
    wb_write(3'd0, 32'h1);
    step(1);
    check("s_setup", mod_in_o, 32'h00A4_0000);
    check("s_busy", 32'(busy_o), 32'd1);
    step(3);
    check("s_hi0", mod_in_o, 32'h00A5_0000);
    step(2);
    check("s_hi2", mod_in_o, 32'h00A5_0000);
    step(1);
    check("s_lo", mod_in_o, 32'h00A4_0000);
    step(4);
    check("s_io_out", 32'(io_out_o), 32'h5A);
    check("s_setup2", mod_in_o, 32'h00A4_0000);
    wb_read("s_out", 3'd4, 32'h025A);
    wb_read("s_status", 3'd5, 32'h3);
    wb_write(3'd0, 32'h0);
    wait_idle("s_idle");
    check("s_idle_mod", mod_in_o, 32'd0);
    wb_read("s_done", 3'd5, 32'h2);
    wb_write(3'd5, 32'h2);
    wb_read("s_clr", 3'd5, 32'h0);

    // Scan mode, DIV=1, slot k returns 0x10+k
    wb_write(3'd1, 32'd0);
    wb_write(3'd2, 32'd1);
    mod_out_i = 32'h1312_1110;
    wb_write(3'd0, 32'hB);
    step(5);
    for (int k = 0; k < 5; k++) begin
      check("scan_io", 32'(io_out_o), 32'h10 + 32'(k % 4));
      check("scan_irq", 32'(irq_o), (k >= 3) ? 32'd1 : 32'd0);
      wb_read("scan_out", 3'd4, {16'd0, 8'(k % 4), 8'h10 + 8'(k % 4)});
      step(3);
    end
    wb_write(3'd0, 32'h8);
    wait_idle("scan_idle");
    wb_write(3'd5, 32'h2);
    check("scan_irq_clr", 32'(irq_o), 32'd0);

    // Clear run during CLK_HI, slot 1, DIV=3
    wb_write(3'd2, 32'd3);
    wb_write(3'd1, 32'd1);
    wb_write(3'd0, 32'h9);
    step(4);
    check("c_hi", mod_in_o, 32'h0000_A500);
    wb_write(3'd0, 32'h8);
    step(5);
    check("c_cap_busy", 32'(busy_o), 32'd1);
    check("c_cap_mod", mod_in_o, 32'h0000_A400);
    step(1);
    check("c_idle_busy", 32'(busy_o), 32'd0);
    check("c_idle_mod", mod_in_o, 32'd0);
    check("c_io_out", 32'(io_out_o), 32'h11);
    check("c_irq", 32'(irq_o), 32'd1);
    wb_read("c_status", 3'd5, 32'h2);
    wb_write(3'd5, 32'h2);
    check("c_irq_clr", 32'(irq_o), 32'd0);
    wb_read("c_status_clr", 3'd5, 32'h0);

    // src=1 from pads, DIV=2, slot 1
    wb_write(3'd2, 32'd2);
    io_in_i = 8'hFF;
    wb_write(3'd0, 32'h5);
    step(1);
    check("p_setup", mod_in_o, 32'h0000_FE00);
    step(2);
    check("p_hi", mod_in_o, 32'h0000_FF00);
    io_in_i = 8'h00;
    step(1);
    check("p_hi_frozen", mod_in_o, 32'h0000_FF00);
    step(1);
    check("p_lo", mod_in_o, 32'h0000_FE00);
    step(3);
    check("p_setup2", mod_in_o, 32'h0000_0000);
    check("p_busy", 32'(busy_o), 32'd1);
    wb_write(3'd0, 32'h0);
    wait_idle("p_idle");

    // DIV=0 behaves as DIV=1, slot 3
    wb_write(3'd2, 32'd0);
    wb_write(3'd1, 32'd3);
    wb_read("d_div0", 3'd2, 32'd0);
    wb_write(3'd0, 32'h1);
    step(2);
    check("d_hi", mod_in_o, 32'hA500_0000);
    step(1);
    check("d_lo", mod_in_o, 32'hA400_0000);
    step(2);
    check("d_io_out", 32'(io_out_o), 32'h13);
    step(1);
    check("d_hi2", mod_in_o, 32'hA500_0000);

    // Back-to-back strobe acks every other cycle
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("b2b_ack", 32'(wbs_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;

    // Asynchronous reset mid-run
    step(1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_mod_in", mod_in_o, 32'd0);
    check("ar_io_out", 32'(io_out_o), 32'd0);
    check("ar_busy", 32'(busy_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wb_read("ar_div", 3'd2, 32'd1);
    wb_read("ar_sel", 3'd1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny_slot_sequencer.md
Name: tiny_slot_sequencer

Overview:
- Controller that shares one Caravel user area among N_MODULES tiny 8-in/8-out user modules.
- Generates each module's clock on input bit 0 and drives data bits 7:1 from a register or from io pins.
- Captures the addressed module's 8-bit output for the pads and for Wishbone readback.
- Sits between the Wishbone slave port/io pads and the user module instances; runs in single-slot or round-robin scan mode.

Parameters:
- N_MODULES, 4: number of user module slots (2..16).
- SEL_W, 4: slot index width (≥ clog2(N_MODULES)).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write
- wbs_sel_i  in  4  ignored (full-word access only)
- wbs_adr_i  in  32  register word address, bits [4:2] decoded
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data
- io_in_i  in  8  external pad inputs (bit 0 unused)
- io_out_o  out  8  last captured module output
- mod_in_o  out  N_MODULES*8  per-slot inputs, slot k at [8k+7:8k], bit 0 = module clock
- mod_out_i  in  N_MODULES*8  per-slot outputs
- busy_o  out  1  FSM not in IDLE
- irq_o  out  1  done & irq_en

Behaviour:
- Reset: all registers 0 except DIV=1; all outputs 0; FSM in IDLE.
- Registers (adr[4:2]):
  - 0 CTRL: [0] run, [1] scan, [2] src (0=IN reg, 1=io_in_i), [3] irq_en
  - 1 SEL
  - 2 DIV[15:0]
  - 3 IN[7:1]
  - 4 OUT: read-only, [7:0] data, [15:8] slot
  - 5 STATUS: [0] busy RO, [1] done, write-1-to-clear
  - Other addresses read 0; writes to them are ignored.
- Wishbone:
  - wbs_ack_o asserts the cycle after stb&cyc when ack is low; held 1 cycle.
  - Writes update on the ack cycle; wbs_dat_o is valid with ack.
  - Back-to-back requests give ack every other cycle.
- SEL writes with value ≥ N_MODULES are ignored; the old value is kept.
- DIV=0 is treated as 1. Half-period counter counts DIV-1 down to 0.
- FSM: IDLE, SETUP, CLK_HI, CLK_LO, CAPTURE.
  - IDLE→SETUP when run=1. Active slot is loaded from SEL on this entry, and on each SETUP entry in single mode.
  - SETUP (DIV cycles): active slot bits[7:1] = data source, bit0 = 0.
  - CLK_HI (DIV cycles): bit0 = 1, data held.
  - CLK_LO (DIV cycles): bit0 = 0, data held.
  - CAPTURE (1 cycle): OUT and io_out_o take mod_out_i of the active slot; OUT[15:8] = slot.
  - After CAPTURE with run=0: go to IDLE and set done.
  - After CAPTURE in single mode: set done, go to SETUP on the same (re-read) SEL.
  - After CAPTURE in scan mode: increment slot, wrapping N_MODULES-1→0. Set done on wrap. Go to SETUP.
- Data source is sampled every SETUP/CLK_HI/CLK_LO cycle only while in SETUP. It is frozen at SETUP exit.
- Non-active slots are driven all-zero. On slot change, the previous slot's inputs go to 0 on the SETUP entry cycle.
- Clearing run mid-period finishes the current period through CAPTURE, then enters IDLE.
- CTRL scan/src changes take effect at the next SETUP.
- Simultaneous done set and W1C clear: set wins.
- Reset mid-operation forces IDLE, zero outputs and clock bit 0 immediately (asynchronous).
- Period per capture = 3*DIV + 1 cycles.

Decomposition:
- Shared package tiny_seq_pkg holds:
  - register offset constants
  - CTRL bit positions
  - FSM state enum
  - DIV reset value
- Sub-module tiny_seq_regs: Wishbone decode, register file, ack generation, done W1C.
- The FSM and the slot mux stay in the top module.

Test Plan:
- Reset: assert wb_rst_n_i low mid-run → mod_in_o=0, io_out_o=0, busy_o=0, DIV reads 1.
- Single mode, N=4, SEL=2, DIV=3, IN=0xA4, run=1 → only mod_in_o[23:16] toggles.
  - Bit0 high for 3 cycles, data 0xA4 with bit0 clear.
  - Capture every 10 cycles; slot 2 returning 0x5A gives OUT=0x025A and io_out_o=0x5A.
- Scan mode, DIV=1, mod_out_i slot k = 0x10+k → OUT sequence 0x0010, 0x0111, 0x0212, 0x0313, 0x0010.
  - done set after the slot-3 capture; irq_o=1 when irq_en=1.
- src=1, io_in_i=0xFF → module sees 0xFE in SETUP and 0xFF in CLK_HI.
  - Changing io_in_i during CLK_HI has no effect until the next SETUP.
- Clear run during CLK_HI → CLK_LO and CAPTURE complete, then IDLE, busy_o=0, done=1.
  - Writing STATUS=0x2 clears done and irq_o.
- Write SEL=7 with N=4 → SEL still reads the prior value.
  - DIV=0 behaves as DIV=1 (4-cycle period).
  - Every access acks exactly one cycle after strobe.
